// File: rtl/vreg_addr_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : vreg_addr_seq_if
// Description : Request / beat handshake bundle for the VRF address sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface vreg_addr_seq_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int OFF_WIDTH  = 8,
  parameter int REG_WIDTH  = 3
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_base;
  logic [REG_WIDTH-1:0]  req_max_reg;
  logic [OFF_WIDTH-1:0]  req_max_off;
  logic [1:0]            req_mode;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [OFF_WIDTH-1:0]  out_off;
  logic                  out_turn;
  logic                  out_first;
  logic                  out_last;
  logic                  busy;

  // Decoder side: issues requests, consumes beats.
  modport master (
    output req_valid, req_base, req_max_reg, req_max_off, req_mode, flush, out_ready,
    input  req_ready, out_valid, out_addr, out_off, out_turn, out_first, out_last, busy
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_base, req_max_reg, req_max_off, req_mode, flush, out_ready,
    output req_ready, out_valid, out_addr, out_off, out_turn, out_first, out_last, busy
  );
endinterface
`default_nettype wire

// File: rtl/vreg_addr_seq.sv
`default_nettype none
// ============================================================================
// Module      : vreg_addr_seq
// Description : Walks a vector register group beat by beat (register x offset,
//               optional widen half) with valid/ready request and beat ports.
// Revision    : 1.0 - initial release
// ============================================================================
module vreg_addr_seq #(
  parameter int VLEN       = 16384,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int OFF_WIDTH  = 8,
  parameter int REG_WIDTH  = 3
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  vreg_addr_seq_if.slave  bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [1:0]           c_MODE_WIDEN    = 2'b01;
  localparam logic [1:0]           c_MODE_WHOLE    = 2'b10;
  localparam logic [OFF_WIDTH-1:0] c_WHOLE_MAX_OFF = OFF_WIDTH'(VLEN / DATA_WIDTH - 1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [REG_WIDTH-1:0]  r_max_reg;
  logic [OFF_WIDTH-1:0]  r_max_off;
  logic                  r_widen;
  logic [REG_WIDTH-1:0]  r_reg;
  logic [OFF_WIDTH-1:0]  r_off;
  logic                  r_turn;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_first;
  logic                  r_last;

  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] w_base_nxt;
  logic [REG_WIDTH-1:0]  w_max_reg_nxt;
  logic [OFF_WIDTH-1:0]  w_max_off_nxt;
  logic                  w_widen_nxt;
  logic [REG_WIDTH-1:0]  w_reg_nxt;
  logic [OFF_WIDTH-1:0]  w_off_nxt;
  logic                  w_turn_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic                  w_first_nxt;
  logic                  w_last_nxt;

  logic                  w_req_ready;
  logic                  w_accept;
  logic                  w_step;
  logic [OFF_WIDTH-1:0]  w_ld_max_off;
  logic                  w_ld_widen;
  logic [REG_WIDTH-1:0]  w_adv_reg;
  logic [OFF_WIDTH-1:0]  w_adv_off;
  logic                  w_adv_turn;
  logic                  w_adv_last;

  // Position of the beat following the one currently presented.
  always_comb begin
    w_adv_reg  = r_reg;
    w_adv_off  = r_off;
    w_adv_turn = 1'b0;
    w_adv_last = 1'b0;
    if (r_widen && !r_turn) begin
      w_adv_turn = 1'b1;
      w_adv_last = (r_reg == r_max_reg) && (r_off == r_max_off);
    end else begin
      if (r_off == r_max_off) begin
        w_adv_off = '0;
        w_adv_reg = r_reg + 1'b1;
      end else begin
        w_adv_off = r_off + 1'b1;
      end
      w_adv_last = (w_adv_reg == r_max_reg) && (w_adv_off == r_max_off) && !r_widen;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_base_nxt    = r_base;
    w_max_reg_nxt = r_max_reg;
    w_max_off_nxt = r_max_off;
    w_widen_nxt   = r_widen;
    w_reg_nxt     = r_reg;
    w_off_nxt     = r_off;
    w_turn_nxt    = r_turn;
    w_addr_nxt    = r_addr;
    w_first_nxt   = r_first;
    w_last_nxt    = r_last;

    w_req_ready = 1'b0;
    case (r_state)
      S_IDLE:  w_req_ready = !bus.flush;
      S_RUN:   w_req_ready = r_last && bus.out_ready && !bus.flush;
      default: w_req_ready = 1'b0;
    endcase
    w_accept = bus.req_valid && w_req_ready;
    w_step   = (r_state == S_RUN) && bus.out_ready;

    w_ld_widen   = (bus.req_mode == c_MODE_WIDEN);
    w_ld_max_off = (bus.req_mode == c_MODE_WHOLE) ? c_WHOLE_MAX_OFF : bus.req_max_off;

    if (bus.flush) begin
      w_state_nxt = S_IDLE;
      w_reg_nxt   = '0;
      w_off_nxt   = '0;
      w_turn_nxt  = 1'b0;
      w_addr_nxt  = '0;
      w_first_nxt = 1'b0;
      w_last_nxt  = 1'b0;
    end else if (w_accept) begin
      // Acceptance also covers the back-to-back case during the last beat.
      w_state_nxt   = S_RUN;
      w_base_nxt    = bus.req_base;
      w_max_reg_nxt = bus.req_max_reg;
      w_max_off_nxt = w_ld_max_off;
      w_widen_nxt   = w_ld_widen;
      w_reg_nxt     = '0;
      w_off_nxt     = '0;
      w_turn_nxt    = 1'b0;
      w_addr_nxt    = bus.req_base;
      w_first_nxt   = 1'b1;
      w_last_nxt    = (bus.req_max_reg == '0) && (w_ld_max_off == '0) && !w_ld_widen;
    end else if (w_step) begin
      if (r_last) begin
        w_state_nxt = S_IDLE;
        w_turn_nxt  = 1'b0;
        w_first_nxt = 1'b0;
        w_last_nxt  = 1'b0;
      end else begin
        w_reg_nxt   = w_adv_reg;
        w_off_nxt   = w_adv_off;
        w_turn_nxt  = w_adv_turn;
        w_addr_nxt  = r_base + ADDR_WIDTH'(w_adv_reg);
        w_first_nxt = 1'b0;
        w_last_nxt  = w_adv_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_max_reg <= '0;
      r_max_off <= '0;
      r_widen   <= 1'b0;
      r_reg     <= '0;
      r_off     <= '0;
      r_turn    <= 1'b0;
      r_addr    <= '0;
      r_first   <= 1'b0;
      r_last    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_base    <= w_base_nxt;
      r_max_reg <= w_max_reg_nxt;
      r_max_off <= w_max_off_nxt;
      r_widen   <= w_widen_nxt;
      r_reg     <= w_reg_nxt;
      r_off     <= w_off_nxt;
      r_turn    <= w_turn_nxt;
      r_addr    <= w_addr_nxt;
      r_first   <= w_first_nxt;
      r_last    <= w_last_nxt;
    end
  end

  assign bus.req_ready = w_req_ready && rst_n;
  assign bus.out_valid = (r_state == S_RUN);
  assign bus.busy      = (r_state == S_RUN);
  assign bus.out_addr  = r_addr;
  assign bus.out_off   = r_off;
  assign bus.out_turn  = r_turn;
  assign bus.out_first = r_first;
  assign bus.out_last  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_vreg_addr_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_vreg_addr_seq
// Description : Self-checking bench; beat lists are expanded per request into a
//               queue and compared cycle by cycle against the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vreg_addr_seq;
  localparam int AW    = 5;
  localparam int OW    = 8;
  localparam int RW    = 3;
  localparam int WHOLE = 16384 / 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vreg_addr_seq_if #(.ADDR_WIDTH(AW), .OFF_WIDTH(OW), .REG_WIDTH(RW)) bus ();

  vreg_addr_seq #(
    .VLEN(16384), .DATA_WIDTH(64), .ADDR_WIDTH(AW), .OFF_WIDTH(OW), .REG_WIDTH(RW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [OW-1:0] off;
    logic          turn;
    logic          first;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    n_chk = 0;
  int    n_err = 0;
  bit    accepted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expand a request into its full beat list.
  function automatic void push_req(logic [AW-1:0] base, logic [RW-1:0] mreg,
                                   logic [OW-1:0] moff, logic [1:0] mode);
    int    nt;
    int    mo;
    beat_t b;
    nt = (mode == 2'b01) ? 2 : 1;
    mo = (mode == 2'b10) ? WHOLE - 1 : int'(moff);
    for (int r = 0; r <= int'(mreg); r++)
      for (int o = 0; o <= mo; o++)
        for (int t = 0; t < nt; t++) begin
          b.addr  = AW'(int'(base) + r);
          b.off   = OW'(o);
          b.turn  = (t == 1);
          b.first = (r == 0) && (o == 0) && (t == 0);
          b.last  = (r == int'(mreg)) && (o == mo) && (t == nt - 1);
          exp_q.push_back(b);
        end
  endfunction

  task automatic step();
    bit ev;
    bit er;
    @(negedge clk);
    ev = (exp_q.size() > 0);
    er = !bus.flush && (!ev || (exp_q[0].last && bus.out_ready));
    chk("out_valid", 32'(bus.out_valid), 32'(ev));
    chk("busy", 32'(bus.busy), 32'(ev));
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    if (ev) begin
      chk("out_addr", 32'(bus.out_addr), 32'(exp_q[0].addr));
      chk("out_off", 32'(bus.out_off), 32'(exp_q[0].off));
      chk("out_turn", 32'(bus.out_turn), 32'(exp_q[0].turn));
      chk("out_first", 32'(bus.out_first), 32'(exp_q[0].first));
      chk("out_last", 32'(bus.out_last), 32'(exp_q[0].last));
    end
    accepted = 1'b0;
    if (bus.flush) begin
      exp_q.delete();
    end else begin
      if (ev && bus.out_ready) void'(exp_q.pop_front());
      if (bus.req_valid && er) begin
        push_req(bus.req_base, bus.req_max_reg, bus.req_max_off, bus.req_mode);
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [AW-1:0] base, input logic [RW-1:0] mreg,
                      input logic [OW-1:0] moff, input logic [1:0] mode);
    bit ok;
    ok = 1'b0;
    bus.req_valid   = 1'b1;
    bus.req_base    = base;
    bus.req_max_reg = mreg;
    bus.req_max_off = moff;
    bus.req_mode    = mode;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (accepted) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_timeout", 32'(ok), 32'd1);
    bus.req_valid   = 1'b0;
    bus.req_base    = AW'($urandom);
    bus.req_max_reg = RW'($urandom);
    bus.req_max_off = OW'($urandom);
    bus.req_mode    = 2'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 5000; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int m;
    bus.req_valid   = 1'b0;
    bus.req_base    = '0;
    bus.req_max_reg = '0;
    bus.req_max_off = '0;
    bus.req_mode    = 2'b00;
    bus.flush       = 1'b0;
    bus.out_ready   = 1'b1;

    #12;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_addr", 32'(bus.out_addr), 32'd0);
    chk("rst_off", 32'(bus.out_off), 32'd0);
    chk("rst_flags", {29'd0, bus.out_turn, bus.out_first, bus.out_last}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(5'd8, 3'd1, 8'd2, 2'b00);  drain();
    send(5'd4, 3'd0, 8'd1, 2'b01);  drain();
    send(5'd2, 3'd0, 8'd3, 2'b10);  drain();
    send(5'd30, 3'd3, 8'd0, 2'b00); drain();
    send(5'd5, 3'd1, 8'd1, 2'b11);  drain();

    // Back-pressure mid-stream, then a single-beat request on the last beat.
    send(5'd10, 3'd1, 8'd2, 2'b00);
    step();
    bus.out_ready = 1'b0;
    repeat (3) step();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() > 1; i++) step();
    bus.req_valid   = 1'b1;
    bus.req_base    = 5'd20;
    bus.req_max_reg = 3'd0;
    bus.req_max_off = 8'd0;
    bus.req_mode    = 2'b00;
    step();
    chk("b2b_accept", 32'(accepted), 32'd1);
    bus.req_valid = 1'b0;
    drain();

    // Flush on beat 2 while a new request is offered.
    send(5'd8, 3'd1, 8'd2, 2'b00);
    step();
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    step();
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    step();
    step();

    // Asynchronous reset mid-request.
    send(5'd8, 3'd1, 8'd2, 2'b00);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("arst_addr", 32'(bus.out_addr), 32'd0);
    chk("arst_off", 32'(bus.out_off), 32'd0);
    chk("arst_flags", {29'd0, bus.out_turn, bus.out_first, bus.out_last}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    step();

    for (int c = 0; c < 4000; c++) begin
      m = int'($urandom % 16);
      bus.req_valid   = ($urandom % 3) == 0;
      bus.req_base    = AW'($urandom);
      bus.req_max_reg = RW'($urandom % 4);
      bus.req_max_off = OW'($urandom % 6);
      bus.req_mode    = (m == 0) ? 2'b10 : ((m % 4) == 2) ? 2'b11 : 2'(m % 2);
      bus.out_ready   = ($urandom % 4) != 0;
      bus.flush       = ($urandom % 64) == 0;
      step();
    end
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/vreg_addr_seq.md
Name: vreg_addr_seq

Overview:
- Parametrised successor to the vector-register address generator.
- Walks a register group beat by beat: register index × in-register offset.
- Adds a valid/ready request and output handshake with back-pressure, back-to-back requests, selectable widening and whole-register modes, and a synchronous flush.
- Sits between the vector instruction decoder and the VRF read/write port address muxes; one instance per VRF port.

Parameters:
- VLEN, 16384, vector register length in bits.
- DATA_WIDTH, 64, VRF port width in bits; one beat = one DATA_WIDTH word.
- ADDR_WIDTH, 5, VRF register address width (32 registers).
- OFF_WIDTH, 8, offset width; must be >= log2(VLEN/DATA_WIDTH).
- REG_WIDTH, 3, width of the register-within-group index (LMUL up to 8).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_base  in  ADDR_WIDTH  base register of the group.
- req_max_reg  in  REG_WIDTH  last register index in the group (LMUL-1).
- req_max_off  in  OFF_WIDTH  last offset within each register.
- req_mode  in  2  00 normal, 01 widen, 10 whole-register, 11 treated as normal.
- flush  in  1  synchronous abort.
- out_valid  out  1  beat valid.
- out_ready  in  1  consumer accepts beat.
- out_addr  out  ADDR_WIDTH  (base + reg) mod 2^ADDR_WIDTH.
- out_off  out  OFF_WIDTH  current offset.
- out_turn  out  1  widen half select (0 first, 1 second); 0 in other modes.
- out_first  out  1  first beat of request.
- out_last  out  1  last beat of request.
- busy  out  1  a request is in flight.

Behaviour:
- Async reset: state IDLE; out_valid, out_first, out_last, out_turn, busy = 0; out_addr, out_off = 0; req_ready = 0 while rst_n low.
- States:
  - IDLE: req_ready = 1, out_valid = 0.
  - RUN: out_valid = 1, busy = 1.
- On acceptance: latch base, max_reg, max_off and mode. reg = 0, off = 0, turn = 0.
  - Whole-register mode: latched max_off = VLEN/DATA_WIDTH-1; req_max_off ignored.
- Latency: all outputs registered; the first beat appears the cycle after acceptance.
- A beat advances only on out_valid & out_ready. Otherwise all outputs hold stable.
- Advance order:
  - Widen mode: turn toggles first; position advances only when turn = 1.
  - Then off increments; when off == max_off, off -> 0 and reg increments.
- Beat counts:
  - Normal and whole-register: (max_reg+1)*(max_off+1) beats.
  - Widen: twice that, each (reg,off) issued with turn 0 then turn 1.
- out_first = 1 only on the first beat.
- out_last = 1 when reg == max_reg & off == max_off & (turn | mode != widen).
  - Single-beat request (max_reg = 0, max_off = 0, normal mode): out_first = out_last = 1.
- req_ready in RUN = out_last & out_ready & ~flush.
  - Back-to-back: a request accepted in the last-beat handshake cycle produces its first beat the next cycle, with no bubble.
  - Otherwise RUN -> IDLE after the last-beat handshake.
- out_addr wraps modulo 2^ADDR_WIDTH. Example: base 30, reg 3 -> 1.
- flush (any state):
  - Next cycle IDLE, out_valid = 0; in-flight request dropped.
  - Any request presented in the flush cycle is not accepted: req_ready = 0 while flush is high.
- Reset mid-operation: immediate return to IDLE; no residual beats after release.
- Inputs other than the handshake signals are sampled only at acceptance; later changes have no effect on an active request.

Test Plan:
- Normal mode: base 8, max_reg 1, max_off 2, out_ready = 1 -> 6 beats (addr,off) = (8,0)(8,1)(8,2)(9,0)(9,1)(9,2); first on beat 1, last on beat 6; then IDLE.
- Widen mode: base 4, max_reg 0, max_off 1 -> (4,0,t0)(4,0,t1)(4,1,t0)(4,1,t1); out_last only on the 4th beat.
- Whole-register mode: base 2, max_reg 0, req_max_off = 3 (ignored) -> 256 beats, offsets 0..255 at addr 2; out_last at off 255.
- Back-pressure and back-to-back: hold out_ready = 0 for 3 cycles mid-stream -> outputs frozen. Present a second request (base 20, single beat) during the last beat of the first -> accepted that cycle, beat (20,0) next cycle with first = last = 1.
- Wrap: base 30, max_reg 3, max_off 0 -> out_addr 30, 31, 0, 1.
- Flush on beat 2 of a 6-beat request -> out_valid = 0 next cycle and req_ready = 1. Async rst_n pulse mid-request -> all outputs 0 immediately.
